// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline package: per-stage payload structs and their bubble constants.
// A pipe_stage_buf instance uses $bits(<stage>_t) as WIDTH and <STAGE>_BUBBLE as RESET_VAL.
package pipe_stage_buf_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int OCC_W    = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic             instr_valid;
    logic [XLEN-1:0]  pc;
    logic [31:0]      instr;
  } if_id_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    alu_op_e           alu_op;
    wb_sel_e           wb_sel;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    wb_sel_e           wb_sel;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   pc_plus4;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wb_data;
  } mem_wb_t;

  // Bubbles keep every control bit low so an inserted entry behaves as a NOP.
  localparam if_id_t  IF_ID_BUBBLE  = '0;
  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  function automatic logic [OCC_W-1:0] entry_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for any perf event counter.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic saturated;

  assign saturated = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !saturated) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready stage buffer with flush, bubble insertion and a stall counter.
// Define PIPE_SKID_EN for the two-entry variant with a registered in_ready.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;
  logic             main_open;

  assign out_fire  = main_valid && out_ready;
  assign in_fire   = in_valid && in_ready;
  assign main_open = !main_valid || out_fire;

  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef PIPE_SKID_EN
  // Ready comes straight from the skid flop so out_ready never reaches in_ready.
  assign in_ready  = !skid_valid;
  assign occupancy = entry_count(main_valid, skid_valid);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
    end else if (main_open) begin
      if (skid_valid) begin
        skid_valid <= 1'b0;
        skid_data  <= RESET_VAL;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign skid_valid = 1'b0;
  assign skid_data  = RESET_VAL;
  assign in_ready   = main_open;
  assign occupancy  = {1'b0, main_valid};
`endif

  // The skid entry is older than anything arriving this cycle, so it wins the refill.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
    end else if (main_open) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= RESET_VAL;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (main_valid && !out_ready),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the buffer.
module tb_pipe_stage_buf;

  localparam int               W     = 8;
  localparam logic [W-1:0]     RST_V = 8'hE7;
  localparam int               CW    = 4;
  localparam int               CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_SKID_EN
  localparam bit               SKID  = 1'b1;
`else
  localparam bit               SKID  = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  int            n_checks = 0;
  int            n_pass   = 0;
  bit            chk_en   = 1'b0;

  logic [W-1:0]  model_q[$];
  int            model_cnt = 0;

  pipe_stage_buf #(
    .WIDTH     (W),
    .RESET_VAL (RST_V),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Acceptance rule: a two-entry buffer takes data whenever it is not full;
  // a single-entry buffer only when empty or its entry leaves this cycle.
  function automatic bit exp_ready(input int sz, input logic ordy);
    if (SKID) return sz < 2;
    return (sz == 0) || (ordy === 1'b1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic ordy,
                               input logic fl, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  // FIFO model: pop what leaves, push what is accepted, clear on reset/flush.
  always @(posedge clk) begin
    automatic int sz     = model_q.size();
    automatic bit o_fire = (sz > 0) && (out_ready === 1'b1);
    automatic bit i_fire = (in_valid === 1'b1) && exp_ready(sz, out_ready);
    if (reset === 1'b1) model_cnt = 0;
    else if (sz > 0 && out_ready !== 1'b1 && model_cnt < CNT_MAX) model_cnt++;
    if (reset === 1'b1 || flush === 1'b1) begin
      model_q.delete();
    end else begin
      if (o_fire) void'(model_q.pop_front());
      if (i_fire) model_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic int sz = model_q.size();
      checkOutput("out_valid", 32'(out_valid), 32'(sz > 0));
      checkOutput("out_data", 32'(out_data), (sz > 0) ? 32'(model_q[0]) : 32'(RST_V));
      checkOutput("occupancy", 32'(occupancy), 32'(sz));
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready(sz, out_ready)));
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(model_cnt));
    end
  end

  initial begin
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'hE7);
    checkOutput("rst_stall", 32'(stall_cycles), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_d1", 32'(out_data), 32'h01);
    checkOutput("stream_occ1", 32'(occupancy), 32'd1);
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_d2", 32'(out_data), 32'h02);
    checkOutput("stream_occ2", 32'(occupancy), 32'd1);
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_d3", 32'(out_data), 32'h03);
    checkOutput("stream_occ3", 32'(occupancy), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_drained", 32'(out_valid), 32'd0);

    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_d10", 32'(out_data), 32'h10);
    checkOutput("stall_cnt0", 32'(stall_cycles), 32'd0);
    checkOutput("stall_rdy_a", 32'(in_ready), SKID ? 32'd1 : 32'd0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_cnt1", 32'(stall_cycles), 32'd1);
    checkOutput("stall_occ", 32'(occupancy), SKID ? 32'd2 : 32'd1);
    checkOutput("stall_rdy_b", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_cnt2", 32'(stall_cycles), 32'd2);
    checkOutput("stall_head", 32'(out_data), 32'h10);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("release_valid", 32'(out_valid), SKID ? 32'd1 : 32'd0);
    checkOutput("release_data", 32'(out_data), SKID ? 32'h11 : 32'hE7);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("release_empty", 32'(out_valid), 32'd0);

    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_flush_occ", 32'(occupancy), SKID ? 32'd2 : 32'd1);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_occ", 32'(occupancy), 32'd0);
    checkOutput("flush_data", 32'(out_data), 32'hE7);
    checkOutput("flush_stall_kept", 32'(stall_cycles), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_no55", 32'(out_valid), 32'd0);

    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_cnt", 32'(stall_cycles), 32'd15);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_hold", 32'(stall_cycles), 32'd15);
    checkOutput("sat_head", 32'(out_data), 32'h33);

    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    checkOutput("midstall_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("midstall_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("midstall_rst_cnt", 32'(stall_cycles), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
